// File: rtl/uart_tx_hd.sv
// uart_tx_hd: half-duplex UART transmitter with an active-low line-driver enable.
// Frame: start bit, DATA_BITS data bits sent LSB first, optional even parity bit, stop bit.
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit.
// tx_oe_n is low for the whole frame and high in IDLE, which releases the shared line.
module uart_tx_hd #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_oe_n,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               r_state;
  logic [TW-1:0]        r_timer;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_tx_ready;
  logic                 r_tx_out;
  logic                 r_tx_oe_n;
  logic                 r_busy;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = tx_valid & r_tx_ready & (r_state == S_IDLE);
  assign w_bit_end = (r_timer == TIMER_MAX);

  // Frame sequencer: state, bit timer, shift register and registered line outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_tx_ready <= 1'b0;
      r_tx_out   <= 1'b1;
      r_tx_oe_n  <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      // Timer free-runs inside a frame and wraps on every bit boundary.
      r_timer <= w_bit_end ? '0 : r_timer + TW'(1);
      case (r_state)
        S_IDLE: begin
          r_timer    <= '0;
          r_tx_ready <= 1'b1;
          r_tx_out   <= 1'b1;
          r_tx_oe_n  <= 1'b1;
          r_busy     <= 1'b0;
          if (w_accept) begin
            r_shreg    <= tx_data;
            r_bit_idx  <= '0;
            r_state    <= S_START;
            r_tx_ready <= 1'b0;
            r_tx_out   <= 1'b0;
            r_tx_oe_n  <= 1'b0;
            r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^tx_data;
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_tx_out <= r_shreg[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
              r_state  <= S_PARITY;
              r_tx_out <= r_parity;
`else
              r_state  <= S_STOP;
              r_tx_out <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
              r_shreg   <= r_shreg >> 1;
              r_tx_out  <= r_shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state  <= S_STOP;
            r_tx_out <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_state    <= S_IDLE;
            r_tx_out   <= 1'b1;
            r_tx_oe_n  <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_timer    <= '0;
          r_tx_out   <= 1'b1;
          r_tx_oe_n  <= 1'b1;
          r_tx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign tx_out   = r_tx_out;
  assign tx_oe_n  = r_tx_oe_n;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_hd.sv
// tb_uart_tx_hd: scoreboard bench for uart_tx_hd (CLKS_PER_BIT=4, DATA_BITS=8).
// Stimulus pushes the expected frame; the monitor captures each driven window and compares.
module tb_uart_tx_hd;

  localparam int C = 4;
  localparam int D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = D + 3;
`else
  localparam int NB = D + 2;
`endif
  localparam int FL = NB * C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [D-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_out;
  logic         tx_oe_n;
  logic         busy;

  typedef struct {
    logic [D-1:0] data;
    int           exp_len;
    int           gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_tx_hd #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_oe_n  (tx_oe_n),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Expected line level for frame bit k of byte d.
  function automatic logic exp_bit(input logic [D-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= D) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == D + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: capture each tx_oe_n-low window and compare against the scoreboard head.
  initial begin : monitor
    logic line [0:63];
    int   len;
    int   idle_cnt;
    exp_t e;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_oe_n === 1'b0) begin
        len = 0;
        while (tx_oe_n === 1'b0 && len < 64) begin
          line[len] = tx_out;
          len++;
          @(negedge clk);
        end
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", 32'(len), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("frame_len_%02h", e.data), 32'(len), 32'(e.exp_len));
          if (e.gap >= 0) chk($sformatf("idle_gap_%02h", e.data), 32'(idle_cnt), 32'(e.gap));
          for (int i = 0; i < len && i < e.exp_len; i++)
            chk($sformatf("line_%02h_bit%0d_cyc%0d", e.data, i / C, i % C),
                32'(line[i]), 32'(exp_bit(e.data, i / C)));
        end
        idle_cnt = 1;
      end else begin
        idle_cnt++;
      end
    end
  end

  // Queue the expected frame, present the byte, and check the first cycle after accept.
  task automatic send(input logic [D-1:0] d, input logic [D-1:0] after_d,
                      input int gap, input int exp_len, input bit hold);
    int   n;
    exp_t e;
    e.data = d; e.exp_len = exp_len; e.gap = gap;
    sb_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("accept_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    tx_data = after_d;
    if (!hold) tx_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("post_accept_ready_%02h", d), 32'(tx_ready), 32'd0);
    chk($sformatf("post_accept_out_%02h", d),   32'(tx_out),   32'd0);
    chk($sformatf("post_accept_oe_n_%02h", d),  32'(tx_oe_n),  32'd0);
    chk($sformatf("post_accept_busy_%02h", d),  32'(busy),     32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(sb_q.size()), 32'd0);
    chk("idle_out",   32'(tx_out),   32'd1);
    chk("idle_oe_n",  32'(tx_oe_n),  32'd1);
    chk("idle_ready", 32'(tx_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset values while rst_n is held low.
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_out",   32'(tx_out),   32'd1);
      chk("rst_oe_n",  32'(tx_oe_n),  32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd0);
      chk("rst_busy",  32'(busy),     32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(tx_ready), 32'd1);

    // Single byte: 0,1,0,1,0,0,1,0,1,(parity),1.
    send(8'hA5, 8'h5A, -1, FL, 1'b0);
    drain();

    // Back-to-back with tx_valid held high: one released cycle between frames.
    send(8'h00, 8'hFF, -1, FL, 1'b1);
    send(8'hFF, 8'h00, 1, FL, 1'b0);
    drain();

    // Reset during data bit 3 of 0x3C: frame cut after 4*C+2 driven cycles.
    send(8'h3C, 8'hC3, -1, 4 * C + 2, 1'b0);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out",  32'(tx_out),  32'd1);
    chk("abort_oe_n", 32'(tx_oe_n), 32'd1);
    chk("abort_busy", 32'(busy),    32'd0);
    rst_n = 1'b1;
    send(8'h81, 8'h7E, -1, FL, 1'b0);
    drain();

    // Parity cases (parity bit 1 for 0x07, 0 for 0x03 when compiled in).
    send(8'h07, 8'hF8, -1, FL, 1'b0);
    drain();
    send(8'h03, 8'hFC, -1, FL, 1'b0);
    drain();

    // Input changed right after accept must not affect the frame.
    send(8'h55, 8'hAA, -1, FL, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
